// File: rtl/ov7670_pkg.sv
// Shared OV7670 definitions: pixel mode encodings (common with the capture
// decoder), transmitter FSM states and the 32-bit -> 16-bit pixel packer.
package ov7670_pkg;

  localparam logic [2:0] MODE_RGB444 = 3'b000;
  localparam logic [2:0] MODE_RGB555 = 3'b001;
  localparam logic [2:0] MODE_RGB565 = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  // Pixel layout is {X/R4x, R8, G8, B8}; unknown modes fall back to RGB444.
  function automatic logic [15:0] pack_pixel(input logic [2:0] mode, input logic [31:0] pix);
    logic [15:0] w;
    case (mode)
      MODE_RGB565: w = {pix[23:19], pix[15:10], pix[7:3]};
      MODE_RGB555: w = {1'b0, pix[23:19], pix[15:11], pix[7:3]};
      default:     w = {pix[31:28], pix[23:20], pix[15:12], pix[7:4]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ov7670_timing_gen.sv
// Free-running OV7670 raster timing: line/frame counters, IDLE/RUN FSM,
// registered vsync/href/frame_start and the combinational pixel-slot strobes.
module ov7670_timing_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [2:0] mode_i,
  output logic [2:0] mode_o,
  output logic       pix_slot_o,
  output logic       odd_slot_o,
  output logic       vsync_o,
  output logic       href_o,
  output logic       frame_start_o
);

  localparam int L         = 2 * H_ACTIVE + H_BLANK;
  localparam int F         = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
  localparam int HW        = (L > 1) ? $clog2(L) : 1;
  localparam int VW        = (F > 1) ? $clog2(F) : 1;
  localparam int ACT_FIRST = VS_LINES + VBP_LINES;
  localparam int ACT_END   = ACT_FIRST + V_ACTIVE;
  localparam int H_ACT     = 2 * H_ACTIVE;

  tx_state_e       state_q;
  logic [HW-1:0]   h_cnt_q;
  logic [VW-1:0]   v_cnt_q;
  logic [2:0]      mode_q;
  logic            vsync_q, href_q, frame_start_q;

  logic run, act_line, in_span, h_last, v_last;

  assign run      = (state_q == ST_RUN);
  assign act_line = (int'(v_cnt_q) >= ACT_FIRST) && (int'(v_cnt_q) < ACT_END);
  assign in_span  = run && act_line && (int'(h_cnt_q) < H_ACT);
  assign h_last   = (int'(h_cnt_q) == L - 1);
  assign v_last   = (int'(v_cnt_q) == F - 1);

  // Even byte slots fetch a new pixel; odd slots replay its stored low byte.
  assign pix_slot_o = in_span && !h_cnt_q[0];
  assign odd_slot_o = in_span && h_cnt_q[0];

  assign mode_o        = mode_q;
  assign vsync_o       = vsync_q;
  assign href_o        = href_q;
  assign frame_start_o = frame_start_q;

  // Raster FSM; outputs are registered from the current counter position,
  // so frame_start lines up with the first vsync cycle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= MODE_RGB444;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vsync_q       <= run && (int'(v_cnt_q) < VS_LINES);
      href_q        <= in_span;
      frame_start_q <= run && (h_cnt_q == '0) && (v_cnt_q == '0);
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_q <= ST_RUN;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            mode_q  <= mode_i;
          end
        end
        ST_RUN: begin
          if (h_last) begin
            h_cnt_q <= '0;
            if (v_last) begin
              v_cnt_q <= '0;
              // en and mode only matter at the frame boundary
              if (en_i) mode_q  <= mode_i;
              else      state_q <= ST_IDLE;
            end else begin
              v_cnt_q <= v_cnt_q + VW'(1);
            end
          end else begin
            h_cnt_q <= h_cnt_q + HW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_stream_tx.sv
// OV7670-style byte stream transmitter: serialises packed pixel words onto d
// (high byte first) under free-running vsync/href timing.
module ov7670_stream_tx
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  mode,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_start,
  output logic        underrun,
  input  logic        underrun_clr
);

  logic [2:0]  mode_q;
  logic        pix_slot, odd_slot;
  logic [15:0] word;
  logic [7:0]  d_q, d_d, lo_q, lo_d;
  logic        underrun_q, underrun_d;

  ov7670_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .VS_LINES (VS_LINES),
    .VBP_LINES(VBP_LINES),
    .VFP_LINES(VFP_LINES)
  ) u_timing (
    .pclk         (pclk),
    .rst          (rst),
    .en_i         (en),
    .mode_i       (mode),
    .mode_o       (mode_q),
    .pix_slot_o   (pix_slot),
    .odd_slot_o   (odd_slot),
    .vsync_o      (vsync),
    .href_o       (href),
    .frame_start_o(frame_start)
  );

  assign word      = pack_pixel(mode_q, pix_data);
  assign pix_ready = pix_slot;
  assign d         = d_q;
  assign underrun  = underrun_q;

  // Byte mux: fresh high byte, stored low byte, or zero outside href.
  // A missing pixel sends two zero bytes and flags underrun (set wins over clear).
  always_comb begin
    d_d        = 8'h00;
    lo_d       = lo_q;
    underrun_d = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (pix_slot) begin
      if (pix_valid) begin
        d_d  = word[15:8];
        lo_d = word[7:0];
      end else begin
        lo_d       = 8'h00;
        underrun_d = 1'b1;
      end
    end else if (odd_slot) begin
      d_d = lo_q;
    end
  end

  // Output byte, low-byte holding register and sticky underrun flag.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      d_q        <= 8'h00;
      lo_q       <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      d_q        <= d_d;
      lo_q       <= lo_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Self-checking bench for ov7670_stream_tx with a small raster, a random pixel
// source, a behavioural capture decoder and raster-position timing expectations.
module tb_ov7670_stream_tx;

  localparam int HA = 4, VA = 2, HB = 3, VS = 1, VBP = 1, VFP = 1;
  localparam int L  = 2 * HA + HB;
  localparam int F  = VS + VBP + VA + VFP;
  localparam int FR = L * F;

  logic        pclk = 1'b0;
  logic        rst, en, pix_valid, underrun_clr;
  logic [2:0]  mode;
  logic [31:0] pix_data;
  logic        pix_ready, vsync, href, frame_start, underrun;
  logic [7:0]  d;

  int n_chk = 0, n_err = 0;

  // source / monitor state
  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] dec_q[$];
  logic [7:0]  byte_q[$];
  logic [31:0] off_pix;
  logic        off_vld, off_rdy;
  logic [7:0]  hi_b;
  bit          hi_pend;
  logic [2:0]  frame_mode;
  int          slot_cnt, last_slots, drop_slot;

  always #5 pclk = ~pclk;

  ov7670_stream_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
  ) dut (
    .pclk(pclk), .rst(rst), .en(en), .mode(mode),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vsync(vsync), .href(href), .d(d), .frame_start(frame_start),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] mode_mask(input logic [2:0] m);
    case (m)
      3'b010:  return 32'h00F8FCF8;
      3'b001:  return 32'h00F8F8F8;
      default: return 32'hF0F0F0F0;
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [15:0] w, input logic [2:0] m);
    case (m)
      3'b010:  return {8'h00, w[15:11], 3'b000, w[10:5], 2'b00, w[4:0], 3'b000};
      3'b001:  return {8'h00, w[14:10], 3'b000, w[9:5], 3'b000, w[4:0], 3'b000};
      default: return {w[15:12], 4'h0, w[11:8], 4'h0, w[7:4], 4'h0, w[3:0], 4'h0};
    endcase
  endfunction

  // position p counted from the first vsync cycle of a frame
  function automatic bit active_pos(input int p);
    int q, line, col;
    q    = p % FR;
    line = q / L;
    col  = q % L;
    return (line >= VS + VBP) && (line < VS + VBP + VA) && (col < 2 * HA);
  endfunction

  function automatic bit exp_href(input int i);  return active_pos(i);            endfunction
  function automatic bit exp_vsync(input int i); return (i % FR) < VS * L;         endfunction
  function automatic bit exp_fs(input int i);    return (i % FR) == 0;             endfunction
  // a pixel requested now appears on d in the next cycle, as an even byte
  function automatic bit exp_ready(input int i);
    return active_pos(i + 1) && (((i + 1) % L) % 2 == 0);
  endfunction

  // One clock: account the previous handshake, capture the byte stream like a
  // decoder would, then offer the next pixel for the coming edge.
  task automatic cyc();
    @(negedge pclk);
    if (off_rdy) exp_q.push_back(off_vld ? (off_pix & mode_mask(frame_mode)) : 32'h0);
    if (frame_start) begin
      frame_mode = mode;
      last_slots = slot_cnt;
      slot_cnt   = 0;
    end
    if (href) begin
      byte_q.push_back(d);
      if (hi_pend) begin
        dec_q.push_back(decode({hi_b, d}, frame_mode));
        hi_pend = 1'b0;
      end else begin
        hi_b    = d;
        hi_pend = 1'b1;
      end
    end else begin
      hi_pend = 1'b0;
    end
    off_rdy = pix_ready;
    if (pix_ready) begin
      if (src_q.size() > 0) off_pix = src_q.pop_front();
      else                  off_pix = $urandom;
      off_vld = (slot_cnt != drop_slot);
      if (!off_vld) drop_slot = -1;
      slot_cnt++;
    end else begin
      off_pix = $urandom;
      off_vld = 1'($urandom_range(0, 1));
    end
    pix_data  = off_pix;
    pix_valid = off_vld;
  endtask

  task automatic wait_fs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 3'b000; pix_valid = 1'b0; pix_data = '0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge pclk);
    n_chk++;
    if ({vsync, href, frame_start, pix_ready} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl got vs/hr/fs/rdy=%b%b%b%b exp 0000", vsync, href, frame_start, pix_ready);
    end
    n_chk++;
    if (d !== 8'h00) begin n_err++; $display("FAIL reset_d got %h exp 00", d); end
    n_chk++;
    if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_chk++;
      if ({vsync, href, frame_start, pix_ready, d} !== 12'h0) begin
        n_err++; $display("FAIL idle_quiet i=%0d got vs=%b hr=%b fs=%b rdy=%b d=%h exp 0", i, vsync, href, frame_start, pix_ready, d);
      end
    end
  endtask

  task automatic test_timing();
    bit ok;
    mode = 3'b010; en = 1'b1;
    wait_fs(10, ok);
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL first_frame_start got none exp pulse within 10 cycles"); end
    for (int i = 0; i < 2 * FR; i++) begin
      if (i > 0) cyc();
      n_chk++;
      if (frame_start !== exp_fs(i)) begin n_err++; $display("FAIL fs i=%0d got %b exp %b", i, frame_start, exp_fs(i)); end
      n_chk++;
      if (vsync !== exp_vsync(i)) begin n_err++; $display("FAIL vsync i=%0d got %b exp %b", i, vsync, exp_vsync(i)); end
      n_chk++;
      if (href !== exp_href(i)) begin n_err++; $display("FAIL href i=%0d got %b exp %b", i, href, exp_href(i)); end
      n_chk++;
      if (pix_ready !== exp_ready(i)) begin n_err++; $display("FAIL pix_ready i=%0d got %b exp %b", i, pix_ready, exp_ready(i)); end
      if (!href) begin
        n_chk++;
        if (d !== 8'h00) begin n_err++; $display("FAIL d_blank i=%0d got %h exp 00", i, d); end
      end
      if (i == FR) begin
        n_chk++;
        if (last_slots != HA * VA) begin n_err++; $display("FAIL pixels_per_frame got %0d exp %0d", last_slots, HA * VA); end
      end
    end
  endtask

  typedef struct { logic [2:0] m; logic [31:0] pix; logic [7:0] b0, b1; } pvec_t;

  task automatic test_packing();
    pvec_t tv[3];
    bit ok;
    tv[0] = '{3'b010, 32'h00A05028, 8'hA2, 8'h85};
    tv[1] = '{3'b001, 32'h00A05028, 8'h51, 8'h45};
    tv[2] = '{3'b000, 32'hF0A05030, 8'hFA, 8'h53};
    mode = tv[0].m;
    wait_fs(2 * FR, ok);
    for (int i = 0; i < 3; i++) begin
      wait_fs(2 * FR, ok);
      n_chk++;
      if (!ok) begin n_err++; $display("FAIL pack_fs[%0d] got none exp frame_start", i); end
      // changed mid-frame: must only apply from the next frame on
      if (i < 2) mode = tv[i + 1].m;
      src_q.push_back(tv[i].pix);
      byte_q.delete();
      for (int j = 0; j < FR && byte_q.size() < 2; j++) cyc();
      n_chk++;
      if (byte_q.size() < 2) begin
        n_err++; $display("FAIL pack_bytes[%0d] got %0d bytes exp 2", i, byte_q.size());
      end else begin
        if (byte_q[0] !== tv[i].b0) begin n_err++; $display("FAIL pack_hi[%0d] got %h exp %h", i, byte_q[0], tv[i].b0); end
        n_chk++;
        if (byte_q[1] !== tv[i].b1) begin n_err++; $display("FAIL pack_lo[%0d] got %h exp %h", i, byte_q[1], tv[i].b1); end
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    wait_fs(2 * FR, ok);
    n_chk++;
    if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_pre got %b exp 0", underrun); end
    drop_slot = 1;
    byte_q.delete();
    for (int i = 1; i < FR; i++) begin
      cyc();
      n_chk++;
      if (href !== exp_href(i)) begin n_err++; $display("FAIL ur_href i=%0d got %b exp %b", i, href, exp_href(i)); end
    end
    n_chk++;
    if (byte_q.size() != 2 * HA * VA) begin
      n_err++; $display("FAIL ur_bytes got %0d exp %0d", byte_q.size(), 2 * HA * VA);
    end else if (byte_q[2] !== 8'h00 || byte_q[3] !== 8'h00) begin
      n_err++; $display("FAIL ur_zero_bytes got %h %h exp 00 00", byte_q[2], byte_q[3]);
    end
    n_chk++;
    if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set got %b exp 1", underrun); end
    repeat (20) cyc();
    n_chk++;
    if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_sticky got %b exp 1", underrun); end
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    n_chk++;
    if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_clr got %b exp 0", underrun); end
    // clear and set on the same edge: set wins
    wait_fs(2 * FR, ok);
    drop_slot = 0;
    for (int j = 0; j < FR; j++) begin
      cyc();
      if (pix_ready) break;
    end
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    n_chk++;
    if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_prio got %b exp 1", underrun); end
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    exp_q.delete();
    dec_q.delete();
  endtask

  task automatic test_en_drop();
    bit ok;
    wait_fs(2 * FR, ok);
    repeat (10) cyc();
    en = 1'b0;
    mode = 3'b001;
    for (int i = 11; i < FR; i++) begin
      cyc();
      n_chk++;
      if (href !== exp_href(i)) begin n_err++; $display("FAIL drain_href i=%0d got %b exp %b", i, href, exp_href(i)); end
    end
    n_chk++;
    if (slot_cnt != HA * VA) begin n_err++; $display("FAIL drain_pixels got %0d exp %0d", slot_cnt, HA * VA); end
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_chk++;
      if ({vsync, href, frame_start, pix_ready, d} !== 12'h0) begin
        n_err++; $display("FAIL stopped i=%0d got vs=%b hr=%b fs=%b rdy=%b d=%h exp 0", i, vsync, href, frame_start, pix_ready, d);
      end
    end
    en = 1'b1;
    wait_fs(10, ok);
    n_chk++;
    if (!ok) begin n_err++; $display("FAIL restart_fs got none exp pulse within 10 cycles"); end
  endtask

  task automatic test_loopback();
    logic [2:0] ml[5];
    bit ok;
    ml = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
    for (int m = 0; m < 5; m++) begin
      mode = ml[m];
      wait_fs(2 * FR, ok);
      wait_fs(2 * FR, ok);
      exp_q.delete();
      dec_q.delete();
      repeat (FR - 1) cyc();
      n_chk++;
      if (exp_q.size() != HA * VA || dec_q.size() != HA * VA) begin
        n_err++; $display("FAIL loop_count mode=%b got acc=%0d dec=%0d exp %0d", ml[m], exp_q.size(), dec_q.size(), HA * VA);
      end else begin
        for (int k = 0; k < HA * VA; k++) begin
          n_chk++;
          if (dec_q[k] !== exp_q[k]) begin
            n_err++; $display("FAIL loop_pix mode=%b k=%0d got %h exp %h", ml[m], k, dec_q[k], exp_q[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    wait_fs(2 * FR, ok);
    for (int j = 0; j < FR && !href; j++) cyc();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({vsync, href, frame_start, pix_ready, d, underrun} !== 13'h0) begin
      n_err++; $display("FAIL async_reset got vs=%b hr=%b fs=%b rdy=%b d=%h ur=%b exp 0", vsync, href, frame_start, pix_ready, d, underrun);
    end
    @(negedge pclk);
    rst = 1'b0;
    off_rdy = 1'b0;
    wait_fs(10, ok);
    n_chk++;
    if (!ok || vsync !== 1'b1) begin n_err++; $display("FAIL post_reset_fs got ok=%b vs=%b exp 1 1", ok, vsync); end
  endtask

  initial begin
    off_rdy = 1'b0; off_vld = 1'b0; off_pix = '0; hi_b = '0; hi_pend = 1'b0;
    frame_mode = 3'b000; slot_cnt = 0; last_slots = 0; drop_slot = -1;
    test_reset();
    test_timing();
    test_packing();
    test_underrun();
    test_en_drop();
    test_loopback();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
